seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Parametrised multiplexed seven-segment scan controller for the board display path, generalising the 4-digit fixed-rate scanner. It time-multiplexes DIGITS hex digits onto shared active-low segment/anode lines, adds per-digit decimal points and enables, PWM brightness, and tear-free double-buffered updates committed only at frame boundaries. It sits between the CPU debug/MMIO register file and the board pins.

## Interface
- DIGITS, 8, number of digits scanned (1..16)
- CLK_DIV, 100000, clk cycles per digit slot (>= 2)
- PWM_BITS, 4, brightness resolution in bits (1..8)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- hex  in  4*DIGITS  digit values; digit i = hex[4i+3:4i]
- dp_in  in  DIGITS  per-digit decimal point request, 1 = lit
- digit_en  in  DIGITS  per-digit enable, 0 = digit dark
- brightness  in  PWM_BITS  duty code; all-ones = full on
- load  in  1  one-cycle strobe capturing hex/dp_in/digit_en/brightness into shadow
- an  out  DIGITS  anodes, active-low, registered
- seg  out  7  segments {g..a}, active-low, registered
- dp  out  1  decimal point, active-low, registered
- frame_done  out  1  one-cycle pulse when scan wraps from digit DIGITS-1 to 0
- pending  out  1  shadow holds an uncommitted load

## Operation
- Two register sets: shadow (written on load) and active (drives display). Load with pending=1 overwrites shadow; pending stays 1.
- Commit: on the frame-boundary cycle (slot counter = CLK_DIV-1 and sel = DIGITS-1), if pending or load is high, active <= shadow (or the load inputs directly when load is high that cycle) and pending clears.
- Slot counter counts 0..CLK_DIV-1, wraps; on wrap sel advances, DIGITS-1 wraps to 0.
- PWM counter, PWM_BITS wide, free-runs every cycle; digit drives only while pwm_cnt <= active brightness. brightness = 0 gives 1/2^PWM_BITS duty.
- Digit sel lit when active digit_en[sel]=1 and PWM on (and not blanked, see Configuration): an[sel]=0, all other anodes 1, seg = ~decode(nibble), dp = ~dp_in[sel].
- Digit dark: an all 1, seg = 7'h7F, dp = 1.
- Decode: standard hex 0-F (A,b,C,d,E,F), bit 0 = segment a.

## Timing
- Reset values: an all ones, seg 7'h7F, dp 1, frame_done 0, pending 0; sel, slot counter, PWM counter, shadow and active registers all zero.
- Output latency: an/seg/dp reflect sel/active/pwm state one clk after that state changes.
- frame_done asserts on the cycle after the commit cycle, for exactly one cycle; period DIGITS*CLK_DIV cycles.
- load on the commit cycle: takes effect that boundary; pending never rises.
- load earlier in a frame: pending=1 the next cycle until commit.
- Reset mid-scan: immediate blank, scan restarts at digit 0, pending load discarded.
- DIGITS = 1: every slot wrap is a frame boundary.

## Configuration
- SEG_LZ_BLANK_EN defined: leading-zero blanking. Scanning from digit DIGITS-1 downward, each enabled digit with nibble 0 and dp_in 0 is dark until the first nonzero nibble or set dp; digit 0 is never blanked. Blank mask is computed from active registers at commit.
- Undefined: no blanking; every enabled digit displays its nibble, including zeros.

## Structure
- Shared package seg_pkg: 7-bit segment typedef, SEG_OFF = 7'h7F constant, hex-to-segment lookup function.
- One sub-module: hex7seg, combinational nibble to active-high segments, one instance on the selected nibble.

## Test plan
- Reset, DIGITS=4, CLK_DIV=4, PWM_BITS=1, brightness=1, no load -> an=4'hF, seg=7'h7F throughout, frame_done every 16 cycles, pending=0.
- load hex=16'h1234, digit_en=4'hF, brightness=1 mid-frame -> pending=1 until boundary; next frame shows sequence an=1110 seg=~0x66 ('4'), 1101 ~0x4F ('3'), 1011 ~0x5B ('2'), 0111 ~0x06 ('1').
- Two loads in one frame (16'h1111 then 16'h2222) -> only 2222 displayed; single commit.
- load coincident with commit cycle -> new data in the immediately following frame, pending never 1.
- brightness=0 with PWM_BITS=2 -> anode low 1 of every 4 cycles within a slot.
- SEG_LZ_BLANK_EN, hex=16'h0050, digit_en=4'hF -> digits 3,2 dark, 1 shows '5', 0 shows '0'; hex=0 -> only digit 0 lit.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the seven-segment display path.
//   seg_t       7-bit segment vector {g,f,e,d,c,b,a}, bit 0 = segment a
//   SEG_OFF     active-low pattern with every segment dark
//   hex_to_seg  nibble to active-high segment pattern (0-9, A, b, C, d, E, F)
`timescale 1ns/1ps
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to active-high segment decoder.
//   nibble  in   4  hex digit value
//   seg     out  7  segments {g..a}, 1 = lit
`timescale 1ns/1ps
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan controller.
// Scans DIGITS hex digits onto shared active-low anode/segment lines with
// per-digit decimal points and enables, PWM brightness, and a shadow/active
// register pair so new values only appear at a frame boundary.
//   clk         in   1           system clock (rising edge)
//   reset       in   1           asynchronous active-high reset
//   hex         in   4*DIGITS    digit values, digit i = hex[4i+3:4i]
//   dp_in       in   DIGITS      decimal point request per digit, 1 = lit
//   digit_en    in   DIGITS      digit enable, 0 = dark
//   brightness  in   PWM_BITS    duty code, all-ones = full on
//   load        in   1           strobe capturing the inputs into the shadow set
//   an          out  DIGITS      anodes, active-low
//   seg         out  7           segments {g..a}, active-low
//   dp          out  1           decimal point, active-low
//   frame_done  out  1           pulse on the cycle after a frame boundary
//   pending     out  1           shadow holds an uncommitted load
// Optional macro SEG_LZ_BLANK_EN enables leading-zero blanking.
`timescale 1ns/1ps
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int CLK_DIV  = 100000,
  parameter int PWM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int SLOT_W = $clog2(CLK_DIV);
  localparam int SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLK_DIV - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(DIGITS - 1);

  logic [SLOT_W-1:0]   slot_cnt;
  logic [SEL_W-1:0]    sel;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic [4*DIGITS-1:0] sh_hex, act_hex;
  logic [DIGITS-1:0]   sh_dp, act_dp;
  logic [DIGITS-1:0]   sh_en, act_en;
  logic [PWM_BITS-1:0] sh_bri, act_bri;

  logic slot_wrap, boundary, commit;
  logic [4*DIGITS-1:0] cmt_hex;
  logic [DIGITS-1:0]   cmt_dp, cmt_en;
  logic [PWM_BITS-1:0] cmt_bri;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign boundary  = slot_wrap && (sel == SEL_LAST);
  assign commit    = boundary && (pending || load);

  // A load on the boundary cycle bypasses the shadow so it lands this frame.
  assign cmt_hex = load ? hex        : sh_hex;
  assign cmt_dp  = load ? dp_in      : sh_dp;
  assign cmt_en  = load ? digit_en   : sh_en;
  assign cmt_bri = load ? brightness : sh_bri;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      sel      <= '0;
      pwm_cnt  <= '0;
      pending  <= 1'b0;
      sh_hex   <= '0;
      sh_dp    <= '0;
      sh_en    <= '0;
      sh_bri   <= '0;
      act_hex  <= '0;
      act_dp   <= '0;
      act_en   <= '0;
      act_bri  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (slot_wrap) begin
        slot_cnt <= '0;
        sel      <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (load) begin
        sh_hex <= hex;
        sh_dp  <= dp_in;
        sh_en  <= digit_en;
        sh_bri <= brightness;
      end
      if (commit) begin
        act_hex <= cmt_hex;
        act_dp  <= cmt_dp;
        act_en  <= cmt_en;
        act_bri <= cmt_bri;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] blank_mask;

  // Walk down from the top digit; zeros without a dp stay dark until the
  // first visible content. Digit 0 is never blanked.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] h,
                                                input logic [DIGITS-1:0]   d);
    logic [DIGITS-1:0] m;
    logic lead;
    m    = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if ((h[4*i +: 4] != 4'h0) || d[i]) lead = 1'b0;
      m[i] = lead;
    end
    return m;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blank_mask <= '0;
    else if (commit) blank_mask <= lz_mask(cmt_hex, cmt_dp);
  end
`endif

  logic [3:0]        nib_sel;
  logic              en_sel, dp_sel, blank_sel, lit_p0;
  logic [DIGITS-1:0] an_p0;
  logic [6:0]        seg_dec;

  always_comb begin
    nib_sel   = 4'h0;
    en_sel    = 1'b0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == SEL_W'(i)) begin
        nib_sel = act_hex[4*i +: 4];
        en_sel  = act_en[i];
        dp_sel  = act_dp[i];
`ifdef SEG_LZ_BLANK_EN
        blank_sel = blank_mask[i];
`endif
      end
    end
    lit_p0 = en_sel && !blank_sel && (pwm_cnt <= act_bri);
    an_p0  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (lit_p0 && (sel == SEL_W'(i))) an_p0[i] = 1'b0;
    end
  end

  hex7seg u_dec (
    .nibble (nib_sel),
    .seg    (seg_dec)
  );

  // Stage boundary: registered pin drivers, one cycle behind scan state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_p0;
      seg        <= lit_p0 ? ~seg_dec : SEG_OFF;
      dp         <= lit_p0 ? ~dp_sel : 1'b1;
      frame_done <= boundary;
    end
  end

endmodule
